serial_tx: RTL and testbench

SERIAL_TX -- requirements
Module: serial_tx

---
 rtl/serial_tx.sv | 112 +++++++++++
 tb/tb_serial_tx.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_tx.sv
// Serial transmitter: start bit, DATA_W data bits LSB first, stop bit,
// with every line bit held for CLKS_PER_BIT clocks and all outputs registered.
module serial_tx #(
    parameter int unsigned DATA_W       = 8,
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] din,
    input  logic              load,
    output logic              ready,
    output logic              busy,
    output logic              sout,
    output logic              done
);

    localparam int unsigned TICK_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_t;

    state_t            state;
    logic [DATA_W-1:0] shreg;
    logic [TICK_W-1:0] tick;
    logic [BIT_W-1:0]  bit_cnt;

    logic [DATA_W-1:0] shreg_shr;
    logic              tick_end;

    assign shreg_shr = shreg >> 1;
    assign tick_end  = (tick == TICK_LAST);

    // Outputs are loaded together with the state so they show the new state
    // in the first cycle after each transition edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            shreg   <= '0;
            tick    <= '0;
            bit_cnt <= '0;
            sout    <= 1'b1;
            ready   <= 1'b1;
            busy    <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state   <= START;
                        shreg   <= din;
                        tick    <= '0;
                        bit_cnt <= '0;
                        sout    <= 1'b0;
                        busy    <= 1'b1;
                        ready   <= 1'b0;
                    end
                end
                START: begin
                    if (tick_end) begin
                        state <= DATA;
                        tick  <= '0;
                        sout  <= shreg[0];
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                DATA: begin
                    if (tick_end) begin
                        tick <= '0;
                        if (bit_cnt == BIT_LAST) begin
                            state <= STOP;
                            sout  <= 1'b1;
                        end else begin
                            shreg   <= shreg_shr;
                            bit_cnt <= bit_cnt + BIT_W'(1);
                            sout    <= shreg_shr[0];
                        end
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                STOP: begin
                    if (tick_end) begin
                        state <= IDLE;
                        tick  <= '0;
                        sout  <= 1'b1;
                        busy  <= 1'b0;
                        ready <= 1'b1;
                        done  <= 1'b1;
                    end else begin
                        tick <= tick + TICK_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    sout  <= 1'b1;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx.sv
// Bench for serial_tx: two instances (4 and 1 clocks per bit) compared every
// cycle against a frame-position model, plus directed protocol scenarios.
module tb_serial_tx;

    logic       clk = 1'b0;
    logic       rst;
    logic       ld0, ld1;
    logic [7:0] din0, din1;
    logic       so0, bz0, rd0, dq0;
    logic       so1, bz1, rd1, dq1;

    int errors = 0;
    int checks = 0;

    // Model: position inside the current frame (-1 when idle) and frame bits
    int         pos    [2];
    logic [9:0] fr     [2];
    logic       done_e [2];
    int         cpb    [2];

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(4)) dut (
        .clk(clk), .rst(rst), .din(din0), .load(ld0),
        .ready(rd0), .busy(bz0), .sout(so0), .done(dq0)
    );

    serial_tx #(.DATA_W(8), .CLKS_PER_BIT(1)) dut1 (
        .clk(clk), .rst(rst), .din(din1), .load(ld1),
        .ready(rd1), .busy(bz1), .sout(so1), .done(dq1)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_step(input int m, input logic l, input logic [7:0] d);
        done_e[m] = 1'b0;
        if (rst) begin
            pos[m] = -1;
        end else if (pos[m] >= 0) begin
            pos[m]++;
            if (pos[m] == 10 * cpb[m]) begin
                pos[m]    = -1;
                done_e[m] = 1'b1;
            end
        end else if (l) begin
            fr[m]  = {1'b1, d, 1'b0};
            pos[m] = 0;
        end
    endtask

    task automatic check_dut(input int m, input logic s, input logic b, input logic r, input logic dn);
        logic es;
        es = (pos[m] < 0) ? 1'b1 : fr[m][pos[m] / cpb[m]];
        check($sformatf("sout%0d", m),  32'(s),  32'(es));
        check($sformatf("busy%0d", m),  32'(b),  32'(pos[m] >= 0));
        check($sformatf("ready%0d", m), 32'(r),  32'(pos[m] < 0));
        check($sformatf("done%0d", m),  32'(dn), 32'(done_e[m]));
    endtask

    // One clock: model follows the inputs present at the edge, outputs checked 1ns later
    task automatic step();
        @(posedge clk);
        model_step(0, ld0, din0);
        model_step(1, ld1, din1);
        #1;
        check_dut(0, so0, bz0, rd0, dq0);
        check_dut(1, so1, bz1, rd1, dq1);
    endtask

    initial begin
        int n;
        int lows;
        int seen_done;
        logic [9:0] seq;
        logic [9:0] exp_seq;

        cpb[0] = 4; cpb[1] = 1;
        pos[0] = -1; pos[1] = -1;
        fr[0] = '1; fr[1] = '1;
        done_e[0] = 1'b0; done_e[1] = 1'b0;
        rst = 1'b1; ld0 = 1'b0; ld1 = 1'b0; din0 = '0; din1 = '0;

        // Reset state
        step(); step();
        check("rst_sout", 32'(so0), 32'd1);
        check("rst_ready", 32'(rd0), 32'd1);
        rst = 1'b0;
        step();

        // A5 frame: done 40 cycles after the first low cycle
        ld0 = 1'b1; din0 = 8'hA5;
        step();
        ld0 = 1'b0; din0 = 8'h00;
        check("a5_start_low", 32'(so0), 32'd0);
        n = 0;
        while (n < 100 && dq0 !== 1'b1) begin step(); n++; end
        check("a5_done_latency", 32'(n), 32'd40);
        step(); step();

        // 3C frame, FF load at cycle 10 while busy is ignored
        ld0 = 1'b1; din0 = 8'h3C;
        step();
        ld0 = 1'b0;
        for (int i = 1; i < 10; i++) step();
        ld0 = 1'b1; din0 = 8'hFF;
        step();
        ld0 = 1'b0;
        check("3c_ready_busy", 32'(rd0), 32'd0);
        n = 10;
        while (n < 100 && dq0 !== 1'b1) begin step(); n++; end
        check("3c_frame_len", 32'(n), 32'd40);
        step(); step();
        check("3c_no_second_frame", 32'(bz0), 32'd0);

        // 00 then FF loaded in the done cycle: contiguous frames
        ld0 = 1'b1; din0 = 8'h00;
        step();
        ld0 = 1'b0;
        lows = (so0 === 1'b0) ? 1 : 0;
        n = 0;
        while (n < 100 && dq0 !== 1'b1) begin
            step(); n++;
            if (so0 === 1'b0) lows++;
        end
        check("f1_lows", 32'(lows), 32'd36);
        ld0 = 1'b1; din0 = 8'hFF;
        step();
        ld0 = 1'b0;
        check("f2_starts_at_once", 32'(so0), 32'd0);
        lows = (so0 === 1'b0) ? 1 : 0;
        n = 0;
        while (n < 100 && dq0 !== 1'b1) begin
            step(); n++;
            if (so0 === 1'b0) lows++;
        end
        check("f2_lows", 32'(lows), 32'd4);
        check("f2_len", 32'(n), 32'd40);
        step();

        // Reset at cycle 15 of a 5A frame aborts it without done
        ld0 = 1'b1; din0 = 8'h5A;
        step();
        ld0 = 1'b0;
        for (int i = 1; i < 15; i++) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("abort_sout", 32'(so0), 32'd1);
        check("abort_busy", 32'(bz0), 32'd0);
        seen_done = 0;
        for (int i = 0; i < 50; i++) begin
            step();
            if (dq0 === 1'b1) seen_done++;
        end
        check("abort_no_done", 32'(seen_done), 32'd0);
        ld0 = 1'b1; din0 = 8'h81;
        step();
        ld0 = 1'b0;
        n = 0;
        while (n < 100 && dq0 !== 1'b1) begin step(); n++; end
        check("after_abort_81", 32'(n), 32'd40);

        // One clock per bit, din=01
        ld1 = 1'b1; din1 = 8'h01;
        step();
        ld1 = 1'b0;
        seq = '0;
        seq[0] = so1;
        for (int i = 1; i < 10; i++) begin step(); seq[i] = so1; end
        exp_seq = 10'b1000000010;
        check("cpb1_seq", 32'(seq), 32'(exp_seq));
        step();
        check("cpb1_done", 32'(dq1), 32'd1);

        // rst and load together: nothing starts
        rst = 1'b1; ld0 = 1'b1; din0 = 8'h00;
        step();
        rst = 1'b0; ld0 = 1'b0;
        lows = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (so0 !== 1'b1) lows++;
        end
        check("rst_load_dropped", 32'(lows), 32'd0);

        // Random traffic on both instances
        for (int i = 0; i < 1500; i++) begin
            ld0  = ($urandom_range(0, 3) == 0);
            ld1  = ($urandom_range(0, 3) == 0);
            din0 = 8'($urandom);
            din1 = 8'($urandom);
            rst  = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0; ld0 = 1'b0; ld1 = 1'b0;
        for (int i = 0; i < 45; i++) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
